// File: rtl/dco_cbank_ctrl.sv
// Slew-limited DCO capacitor-bank controller: steps a thermometer code toward a
// requested target and drives registered row/column/cell enables for a ROWS x COLS bank.
//
// state | meaning
// IDLE  | code settled, tgt_ready high, accepts new targets
// RAMP  | stepping code toward target by at most MAX_STEP per clock
module dco_cbank_ctrl #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int MAX_STEP = 4,
    localparam int NMAX    = ROWS * COLS,
    localparam int CW      = $clog2(NMAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tgt_valid,
    output logic            tgt_ready,
    input  logic [CW-1:0]   tgt_code,
    input  logic            slew_en,
    input  logic            hold,
    output logic [CW-1:0]   code,
    output logic            busy,
    output logic            sat,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_sel,
    output logic [ROWS-1:0] r_all,
    output logic [NMAX-1:0] cell_en
);

    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [CW-1:0] NMAX_C = CW'(NMAX);
    localparam logic [CW-1:0] STEP_C = CW'(MAX_STEP);
    localparam logic [CW:0]   STEP_W = (CW + 1)'(MAX_STEP);
    localparam logic [CW-1:0] COLS_C = CW'(COLS);

    state_t          state, state_nxt;
    logic [CW-1:0]   target, target_nxt;
    logic [CW-1:0]   code_nxt;
    logic            sat_nxt;
    logic [CW-1:0]   eff;
    logic [CW:0]     diff;
    logic [CW:0]     mag;
    logic [CW-1:0]   f_n;
    logic [CW-1:0]   p_n;
    logic [ROWS-1:0] row_sel_nxt;
    logic [COLS-1:0] col_sel_nxt;
    logic [ROWS-1:0] r_all_nxt;
    logic [NMAX-1:0] cell_en_nxt;

    assign tgt_ready = (state == IDLE);
    assign busy      = (state == RAMP);

    always_comb begin
        state_nxt  = state;
        code_nxt   = code;
        target_nxt = target;
        sat_nxt    = sat;
        eff        = (tgt_code > NMAX_C) ? NMAX_C : tgt_code;
        diff       = {1'b0, target} - {1'b0, code};
        mag        = diff[CW] ? (~diff + 1'b1) : diff;

        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    sat_nxt = (tgt_code > NMAX_C);
                    if (slew_en) begin
                        target_nxt = eff;
                        state_nxt  = RAMP;
                    end else begin
                        code_nxt = eff;
                    end
                end
            end
            RAMP: begin
                if (!hold) begin
                    if (mag <= STEP_W) begin
                        code_nxt  = target;
                        state_nxt = IDLE;
                    end else if (diff[CW]) begin
                        code_nxt = code - STEP_C;
                    end else begin
                        code_nxt = code + STEP_C;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Decode from the next code so vectors land on the same edge as code.
        f_n = code_nxt / COLS_C;
        p_n = code_nxt % COLS_C;
        row_sel_nxt = '0;
        col_sel_nxt = '0;
        r_all_nxt   = '1;
        cell_en_nxt = '0;
        for (int r = 0; r < ROWS; r++) begin
            r_all_nxt[r]   = !(CW'(r) < f_n);
            row_sel_nxt[r] = (CW'(r) == f_n);
        end
        for (int c = 0; c < COLS; c++) begin
            col_sel_nxt[c] = (CW'(c) < p_n);
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cell_en_nxt[r*COLS+c] = (row_sel_nxt[r] & col_sel_nxt[c]) | ~r_all_nxt[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            code    <= '0;
            target  <= '0;
            sat     <= 1'b0;
            row_sel <= ROWS'(1);
            col_sel <= '0;
            r_all   <= '1;
            cell_en <= '0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            target  <= target_nxt;
            sat     <= sat_nxt;
            row_sel <= row_sel_nxt;
            col_sel <= col_sel_nxt;
            r_all   <= r_all_nxt;
            cell_en <= cell_en_nxt;
        end
    end

endmodule

// File: tb/tb_dco_cbank_ctrl.sv
// Bench for dco_cbank_ctrl: directed scenarios plus random traffic against an
// integer-level model of the ramp and the thermometer bank decode.
module tb_dco_cbank_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int MS   = 4;
    localparam int NMAX = ROWS * COLS;
    localparam int CW   = $clog2(NMAX + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            tgt_valid;
    logic            tgt_ready;
    logic [CW-1:0]   tgt_code;
    logic            slew_en;
    logic            hold;
    logic [CW-1:0]   code;
    logic            busy;
    logic            sat;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_sel;
    logic [ROWS-1:0] r_all;
    logic [NMAX-1:0] cell_en;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_code = 0;
    int m_tgt  = 0;
    bit m_ramp = 0;
    bit m_sat  = 0;

    dco_cbank_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_STEP(MS)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .tgt_code(tgt_code), .slew_en(slew_en), .hold(hold), .code(code),
        .busy(busy), .sat(sat), .row_sel(row_sel), .col_sel(col_sel),
        .r_all(r_all), .cell_en(cell_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_cell(input int n);
        logic [63:0] v = '0;
        for (int k = 0; k < NMAX; k++) v[k] = (k < n);
        return v;
    endfunction

    function automatic logic [63:0] m_rall(input int n);
        logic [63:0] v = '0;
        for (int r = 0; r < ROWS; r++) v[r] = !(r < n / COLS);
        return v;
    endfunction

    function automatic logic [63:0] m_rsel(input int n);
        logic [63:0] v = '0;
        for (int r = 0; r < ROWS; r++) v[r] = (r == n / COLS);
        return v;
    endfunction

    function automatic logic [63:0] m_csel(input int n);
        logic [63:0] v = '0;
        for (int c = 0; c < COLS; c++) v[c] = (c < n % COLS);
        return v;
    endfunction

    task automatic model_edge();
        int d;
        int eff;
        if (m_ramp) begin
            if (!hold) begin
                d = m_tgt - m_code;
                if ((d < 0 ? -d : d) <= MS) begin
                    m_code = m_tgt;
                    m_ramp = 0;
                end else begin
                    m_code = m_code + (d > 0 ? MS : -MS);
                end
            end
        end else if (tgt_valid) begin
            eff   = (int'(tgt_code) > NMAX) ? NMAX : int'(tgt_code);
            m_sat = (int'(tgt_code) > NMAX);
            if (slew_en) begin
                m_tgt  = eff;
                m_ramp = 1;
            end else begin
                m_code = eff;
            end
        end
    endtask

    task automatic check_all();
        chk("code",      64'(code),      64'(m_code));
        chk("busy",      64'(busy),      64'(m_ramp));
        chk("tgt_ready", 64'(tgt_ready), 64'(!m_ramp));
        chk("sat",       64'(sat),       64'(m_sat));
        chk("row_sel",   64'(row_sel),   m_rsel(m_code));
        chk("col_sel",   64'(col_sel),   m_csel(m_code));
        chk("r_all",     64'(r_all),     m_rall(m_code));
        chk("cell_en",   64'(cell_en),   m_cell(m_code));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // asynchronous reset applied away from any clock edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_code = 0; m_tgt = 0; m_ramp = 0; m_sat = 0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic drive(input bit v, input int t, input bit s, input bit h);
        tgt_valid = v;
        tgt_code  = CW'(t);
        slew_en   = s;
        hold      = h;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        #2;
        do_reset();
        chk("rst_row_sel", 64'(row_sel), 64'h1);
        step();

        // direct load of 19
        drive(1, 19, 0, 0);
        step();
        chk("d19_r_all",   64'(r_all),   64'hFC);
        chk("d19_row_sel", 64'(row_sel), 64'h04);
        chk("d19_col_sel", 64'(col_sel), 64'h07);
        chk("d19_cell_en", 64'(cell_en), 64'h7FFFF);
        drive(1, 0, 0, 0);
        step();

        // slew 0 -> 10; valid offered during the ramp must be ignored
        drive(1, 10, 1, 0);
        step();
        drive(1, 50, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0);
        step();
        chk("slew10_code", 64'(code), 64'd10);
        step();

        // slew 10 -> 1 with hold on the second step edge
        drive(1, 1, 1, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        hold = 1'b1;
        step();
        hold = 1'b0;
        step();
        step();
        chk("slew1_code", 64'(code), 64'd1);
        chk("slew1_idle", 64'(tgt_ready), 64'd1);

        // over-range clamp, then a normal accept clears sat
        drive(1, 70, 0, 0);
        step();
        chk("clamp_cell_en", 64'(cell_en), 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 5, 0, 0);
        step();
        chk("clear_sat", 64'(sat), 64'd0);

        // reset in the middle of a ramp toward 40
        drive(1, 0, 0, 0);
        step();
        drive(1, 40, 1, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        step();
        chk("mid_code", 64'(code), 64'd8);
        do_reset();
        drive(1, 7, 0, 0);
        step();
        chk("post_rst_code", 64'(code), 64'd7);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end
            drive($urandom_range(2) != 0,
                  ($urandom_range(9) == 0) ? int'($urandom_range(127)) : int'($urandom_range(NMAX)),
                  $urandom_range(1) == 1,
                  $urandom_range(3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dco_cbank_ctrl.md
# dco_cbank_ctrl

Parametrised, slew-limited controller for one DCO capacitor bank organised as a ROWS x COLS unit-cell array. It accepts a target thermometer code over a valid/ready handshake and steps the active code toward it by at most MAX_STEP cells per clock, so the oscillator frequency changes in bounded steps. It drives registered row/column select, row-full and per-cell enable vectors to the bank. It sits between the ADPLL loop-filter/tuning-word logic and the DCO bank cells.

## Interface
Parameters:
- ROWS, 8, number of cell rows (>=2)
- COLS, 8, cells per row (>=2)
- MAX_STEP, 4, maximum code change per clock in slew mode (1..ROWS*COLS)
- Derived: NMAX = ROWS*COLS; CW = $clog2(NMAX+1)

Ports:
- clk  in  1  bank clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- tgt_valid  in  1  target code offered
- tgt_ready  out  1  controller can accept a target
- tgt_code  in  CW  requested number of enabled cells
- slew_en  in  1  1 = ramp, 0 = direct load; sampled only on accept
- hold  in  1  freeze ramp stepping
- code  out  CW  current number of enabled cells
- busy  out  1  ramp in progress
- sat  out  1  last accepted target exceeded NMAX and was clamped
- row_sel  out  ROWS  one-hot partial-row select
- col_sel  out  COLS  thermometer column select within partial row
- r_all  out  ROWS  active-low row-full: 0 = whole row enabled
- cell_en  out  NMAX  cell k = r*COLS+c enabled

## Operation
- Accept = tgt_valid & tgt_ready on a rising clk edge; tgt_ready = (state == IDLE).
- Clamp: eff = min(tgt_code, NMAX); sat <= (tgt_code > NMAX) on accept, held until next accept.
- States IDLE, RAMP; busy = (state == RAMP).
- IDLE, accept, slew_en=0: code <= eff at the accept edge; stay IDLE.
- IDLE, accept, slew_en=1: target <= eff; go RAMP; code unchanged at the accept edge.
- RAMP, hold=1: code and target frozen; stay RAMP.
- RAMP, hold=0: d = target - code (signed, CW+1 bits). If |d| <= MAX_STEP: code <= target, go IDLE. Else code <= code + MAX_STEP or code - MAX_STEP toward target.
- hold has no effect in IDLE; accept is not blocked by hold.
- Decode from the next code value n: F = n / COLS, P = n % COLS.
  - r_all[r] = 0 iff r < F
  - row_sel[r] = 1 iff r == F (all 0 when F == ROWS)
  - col_sel[c] = 1 iff c < P
  - cell_en[r*COLS+c] = (row_sel[r] & col_sel[c]) | ~r_all[r]; exactly n bits set, lowest indices first.
- code never leaves 0..NMAX; no wrap-around.

## Timing
- All outputs registered; decode vectors update on the same edge as code, with no skew.
- Reset: state IDLE, code 0, target 0, busy 0, sat 0, tgt_ready 1, r_all all 1, row_sel = 1 (bit 0), col_sel 0, cell_en 0.
- Direct load: new code/cell_en visible after the accept edge (latency 1).
- Slew: accept at E0; first step at E1; a ramp over distance D with no hold ends at edge ceil(D/MAX_STEP) after E0, or at E1 when D = 0. Each hold cycle adds one edge. tgt_ready rises after the final edge.
- Async rst mid-ramp clears every register immediately; the pending target is discarded.

## Test plan
- Reset then idle: rst pulse -> code 0, cell_en 0, r_all all 1, row_sel 1, tgt_ready 1, busy 0.
- Direct load 8x8, tgt_code 19, slew_en 0 -> next cycle code 19, r_all = 8'b11111100, row_sel = 8'b00000100, col_sel = 8'b00000111, cell_en bits 0..18 set, busy never 1.
- Slew 0->10, MAX_STEP 4 -> code 4, 8, 10 on E1..E3; busy 1 for 3 cycles; tgt_valid ignored while busy.
- Slew down 10->1 with hold=1 during E2 -> code 6, 6, 2, 1; IDLE after 4 edges.
- Over-range tgt_code 70 (NMAX 64), direct -> code 64, sat 1, row_sel 0, r_all 0, cell_en all 1; next accept of 5 clears sat.
- rst asserted mid-ramp (code 8, target 40) -> immediate code 0 and reset decode; new accept works on the first edge after rst deasserts.
